// File: rtl/video_st_pkg.sv
`default_nettype none
// ============================================================================
// Package     : video_st_pkg
// Description : Shared definitions for the camera-to-Avalon-ST packetizer.
//               Holds the pixel width, the FIFO word layout and the
//               packetizer state encoding.
//               FIFO word layout: {sop, eop, data[23:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
package video_st_pkg;

  localparam int DATA_W  = 24;
  localparam int WORD_W  = DATA_W + 2;
  localparam int SOP_BIT = 25;
  localparam int EOP_BIT = 24;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    TERM     = 2'd2
  } state_e;

  // Assembles one FIFO word from its fields.
  function automatic logic [WORD_W-1:0] pack_word(input logic sop,
                                                  input logic eop,
                                                  input logic [DATA_W-1:0] data);
    return {sop, eop, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/st_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : st_sync_fifo
// Description : Show-ahead synchronous FIFO. rd_data always presents the
//               oldest entry while !empty. A write while full is still
//               accepted if a pop happens in the same cycle.
// Ports       : clk     in   clock
//               rst_n   in   asynchronous active-low reset (empties FIFO)
//               wr_en   in   write request
//               wr_data in   write data
//               rd_en   in   pop request (ignored while empty)
//               rd_data out  head-of-queue data
//               full    out  no free entry
//               empty   out  no stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module st_sync_fifo #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push;
  logic              pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = rd_en && !empty;
    push     = wr_en && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  // When full with a pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_st_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : video_st_packetizer
// Description : Packs a camera pixel stream (valid + start-of-frame) into a
//               24-bit Avalon-ST packet stream, one packet per frame of
//               WIDTH*HEIGHT beats. A FIFO absorbs sink back-pressure; frames
//               that are cut short (early sof or overflow) are closed with a
//               zero-data EOP filler beat so the sink never waits forever.
// Ports       : clk_clk           in   system clock
//               reset_reset_n     in   asynchronous active-low reset
//               enable            in   accept new frames (checked at sof)
//               pix_valid         in   pixel valid
//               pix_sof           in   first pixel of frame (with pix_valid)
//               pix_data          in   RGB888 pixel
//               src_data          out  Avalon-ST data
//               src_startofpacket out  first beat of packet
//               src_endofpacket   out  last beat of packet
//               src_valid         out  beat available
//               src_ready         in   sink accepts beat
//               frame_count       out  frames whose EOP was queued (wraps)
//               drop_count        out  truncated frames (saturates)
// Revision    : 1.0 - initial release
// ============================================================================
module video_st_packetizer
  import video_st_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [23:0] pix_data,
  output logic [23:0] src_data,
  output logic        src_startofpacket,
  output logic        src_endofpacket,
  output logic        src_valid,
  input  logic        src_ready,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int PIX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [PIX_W-1:0] LAST_CNT    = PIX_W'(TOTAL - 1);
  localparam logic             SINGLE_BEAT = (TOTAL == 1);

  state_e            state_q, state_d;
  logic [PIX_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [15:0]       drop_count_q, drop_count_d;

  logic              fifo_wr_en;
  logic [WORD_W-1:0] fifo_wr_word;
  logic [WORD_W-1:0] fifo_rd_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              can_write;

  st_sync_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_word),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A write lands only when there is room, or when the head leaves this cycle.
  always_comb begin
    fifo_pop  = !fifo_empty && src_ready;
    can_write = !fifo_full || fifo_pop;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    fifo_wr_en    = 1'b0;
    fifo_wr_word  = '0;

    case (state_q)
      WAIT_SOF: begin
        // Only an enabled sof starts a frame; stray pixels are discarded.
        if (pix_valid && pix_sof && enable) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_word = pack_word(1'b1, SINGLE_BEAT, pix_data);
          if (can_write) begin
            if (SINGLE_BEAT) begin
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              cnt_d   = PIX_W'(1);
              state_d = ACTIVE;
            end
          end
        end
      end

      ACTIVE: begin
        if (pix_valid) begin
          if (pix_sof) begin
            // Short frame: the new sof pixel is discarded and the packet
            // is closed; the next frame must begin with a fresh sof.
            state_d = TERM;
          end else begin
            fifo_wr_en   = 1'b1;
            fifo_wr_word = pack_word(1'b0, (cnt_q == LAST_CNT), pix_data);
            if (!can_write) begin
              state_d = TERM;
            end else if (cnt_q == LAST_CNT) begin
              frame_count_d = frame_count_q + 16'd1;
              cnt_d         = '0;
              state_d       = WAIT_SOF;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      TERM: begin
        // Keep offering the filler EOP until the FIFO takes it.
        fifo_wr_en   = 1'b1;
        fifo_wr_word = pack_word(1'b0, 1'b1, '0);
        if (can_write) begin
          if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
          end
          cnt_d   = '0;
          state_d = WAIT_SOF;
        end
      end

      default: begin
        state_d = WAIT_SOF;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= WAIT_SOF;
      cnt_q         <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Outputs are forced to zero whenever no beat is presented so that the
  // uninitialised storage never leaks onto the bus.
  always_comb begin
    src_valid         = !fifo_empty;
    src_data          = fifo_empty ? '0   : fifo_rd_word[DATA_W-1:0];
    src_startofpacket = fifo_empty ? 1'b0 : fifo_rd_word[SOP_BIT];
    src_endofpacket   = fifo_empty ? 1'b0 : fifo_rd_word[EOP_BIT];
    frame_count       = frame_count_q;
    drop_count        = drop_count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_video_st_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_st_packetizer
// Description : Self-checking bench for video_st_packetizer (4x2 frame,
//               4-deep FIFO). A queue-based reference model predicts the
//               output stream and counters every cycle; directed scenarios
//               also compare the accepted beat stream against literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_st_packetizer;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int DEPTH  = 4;
  localparam int TOTAL  = WIDTH * HEIGHT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        pix_valid;
  logic        pix_sof;
  logic [23:0] pix_data;
  logic [23:0] src_data;
  logic        src_sop;
  logic        src_eop;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  int checks   = 0;
  int failures = 0;

  video_st_packetizer #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .enable            (enable),
    .pix_valid         (pix_valid),
    .pix_sof           (pix_sof),
    .pix_data          (pix_data),
    .src_data          (src_data),
    .src_startofpacket (src_sop),
    .src_endofpacket   (src_eop),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .frame_count       (frame_count),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: queue of buffered beats, whether a frame is open and
  // how many of its pixels were queued, and whether a filler EOP is owed.
  logic [25:0] m_q[$];
  bit          m_in_frame = 1'b0;
  bit          m_term     = 1'b0;
  int          m_idx      = 0;
  logic [15:0] m_frames   = '0;
  logic [15:0] m_drops    = '0;
  bit          m_pop;
  bit          m_room;
  bit          m_push;
  logic [25:0] m_word;

  task automatic model_reset();
    m_q.delete();
    m_in_frame = 1'b0;
    m_term     = 1'b0;
    m_idx      = 0;
    m_frames   = '0;
    m_drops    = '0;
  endtask

  task automatic model_step();
    m_pop  = (m_q.size() != 0) && src_ready;
    m_room = (m_q.size() < DEPTH) || m_pop;
    m_push = 1'b0;
    m_word = '0;
    if (m_term) begin
      if (m_room) begin
        m_push = 1'b1;
        m_word = {2'b01, 24'h0};
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        m_term = 1'b0;
      end
    end else if (!m_in_frame) begin
      if (pix_valid && pix_sof && enable && m_room) begin
        m_push = 1'b1;
        m_word = {1'b1, (TOTAL == 1) ? 1'b1 : 1'b0, pix_data};
        if (TOTAL == 1) m_frames = m_frames + 16'd1;
        else begin
          m_in_frame = 1'b1;
          m_idx      = 1;
        end
      end
    end else if (pix_valid) begin
      if (pix_sof || !m_room) begin
        m_in_frame = 1'b0;
        m_term     = 1'b1;
      end else begin
        m_push = 1'b1;
        m_word = {1'b0, (m_idx == TOTAL - 1) ? 1'b1 : 1'b0, pix_data};
        if (m_idx == TOTAL - 1) begin
          m_frames   = m_frames + 16'd1;
          m_in_frame = 1'b0;
        end else begin
          m_idx++;
        end
      end
    end
    if (m_pop)  void'(m_q.pop_front());
    if (m_push) m_q.push_back(m_word);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare + beat log ----------------
  logic [25:0] out_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", 32'(src_valid), 32'd0);
        chk("rst_data",  32'(src_data),  32'd0);
        chk("rst_sop",   32'(src_sop),   32'd0);
        chk("rst_eop",   32'(src_eop),   32'd0);
        chk("rst_fc",    32'(frame_count), 32'd0);
        chk("rst_dc",    32'(drop_count),  32'd0);
      end else begin
        chk("valid", 32'(src_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
          chk("data", 32'(src_data), 32'(m_q[0][23:0]));
          chk("sop",  32'(src_sop),  32'(m_q[0][25]));
          chk("eop",  32'(src_eop),  32'(m_q[0][24]));
        end
        chk("frame_count", 32'(frame_count), 32'(m_frames));
        chk("drop_count",  32'(drop_count),  32'(m_drops));
        if (src_valid && src_ready) out_log.push_back({src_sop, src_eop, src_data});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic s, input logic [23:0] d);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 24'h0);
  endtask

  // Full frame: sof pixel with base+1, then base+2..base+TOTAL.
  task automatic frame(input logic [23:0] base);
    drive(1'b1, 1'b1, base + 24'd1);
    for (int i = 2; i <= TOTAL; i++) drive(1'b1, 1'b0, base + 24'(i));
  endtask

  task automatic beat_is(input string name, input int i, input logic sop,
                         input logic eop, input logic [23:0] d);
    if (i < out_log.size()) chk(name, 32'(out_log[i]), 32'({sop, eop, d}));
    else chk(name, 32'hDEAD_BEEF, 32'({sop, eop, d}));
  endtask

  task automatic frame_beats(input string name, input int first, input logic [23:0] base);
    for (int i = 0; i < TOTAL; i++)
      beat_is(name, first + i, (i == 0), (i == TOTAL - 1), base + 24'(i + 1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    src_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_lit", 32'(src_valid), 32'd0);
    chk("reset_fc_lit", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 1. Normal frame.
    out_log.delete();
    frame(24'h000000);
    idle(4);
    chk("t1_beats", 32'(out_log.size()), 32'd8);
    frame_beats("t1_beat", 0, 24'h000000);
    chk("t1_fc", 32'(frame_count), 32'd1);
    chk("t1_dc", 32'(drop_count), 32'd0);

    // 2. Back-pressure overflow.
    out_log.delete();
    src_ready = 1'b0;
    frame(24'h000010);
    idle(2);
    src_ready = 1'b1;
    idle(8);
    chk("t2_beats", 32'(out_log.size()), 32'd5);
    for (int i = 0; i < 4; i++) beat_is("t2_beat", i, (i == 0), 1'b0, 24'h11 + 24'(i));
    beat_is("t2_filler", 4, 1'b0, 1'b1, 24'h0);
    chk("t2_dc", 32'(drop_count), 32'd1);
    chk("t2_fc", 32'(frame_count), 32'd1);

    // 3. Early sof.
    out_log.delete();
    drive(1'b1, 1'b1, 24'h21);
    drive(1'b1, 1'b0, 24'h22);
    drive(1'b1, 1'b0, 24'h23);
    frame(24'h000030);
    frame(24'h000040);
    idle(4);
    chk("t3_beats", 32'(out_log.size()), 32'd12);
    for (int i = 0; i < 3; i++) beat_is("t3_beat", i, (i == 0), 1'b0, 24'h21 + 24'(i));
    beat_is("t3_filler", 3, 1'b0, 1'b1, 24'h0);
    frame_beats("t3_next", 4, 24'h000040);
    chk("t3_dc", 32'(drop_count), 32'd2);
    chk("t3_fc", 32'(frame_count), 32'd2);

    // 4. Stray pixels, long frame, disabled frame.
    out_log.delete();
    drive(1'b1, 1'b0, 24'h51);
    drive(1'b1, 1'b0, 24'h52);
    frame(24'h000060);
    drive(1'b1, 1'b0, 24'h69);
    drive(1'b1, 1'b0, 24'h6A);
    drive(1'b1, 1'b0, 24'h6B);
    enable = 1'b0;
    frame(24'h000070);
    enable = 1'b1;
    idle(4);
    chk("t4_beats", 32'(out_log.size()), 32'd8);
    frame_beats("t4_beat", 0, 24'h000060);
    chk("t4_fc", 32'(frame_count), 32'd3);

    // 5. Asynchronous reset mid-frame.
    drive(1'b1, 1'b1, 24'h81);
    for (int i = 2; i <= 5; i++) drive(1'b1, 1'b0, 24'h80 + 24'(i));
    chk("t5_pre_valid", 32'(src_valid), 32'd1);
    #2;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    #1;
    chk("t5_valid_now", 32'(src_valid), 32'd0);
    chk("t5_fc_now", 32'(frame_count), 32'd0);
    chk("t5_dc_now", 32'(drop_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    out_log.delete();
    frame(24'h000090);
    idle(4);
    chk("t5_beats", 32'(out_log.size()), 32'd8);
    frame_beats("t5_beat", 0, 24'h000090);
    chk("t5_fc", 32'(frame_count), 32'd1);

    // 6. Full FIFO with a simultaneous pop.
    out_log.delete();
    src_ready = 1'b0;
    drive(1'b1, 1'b1, 24'hA1);
    for (int i = 2; i <= 4; i++) drive(1'b1, 1'b0, 24'hA0 + 24'(i));
    chk("t6_full", 32'(dut.fifo_full), 32'd1);
    src_ready = 1'b1;
    for (int i = 5; i <= 8; i++) drive(1'b1, 1'b0, 24'hA0 + 24'(i));
    idle(6);
    chk("t6_beats", 32'(out_log.size()), 32'd8);
    frame_beats("t6_beat", 0, 24'h0000A0);
    chk("t6_dc", 32'(drop_count), 32'd0);
    chk("t6_fc", 32'(frame_count), 32'd2);

    // 7. Randomised traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 7) != 0);
      src_ready = ($urandom_range(0, 3) != 0);
      if ((i / 200) % 2 == 1) src_ready = ($urandom_range(0, 3) == 0);
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 24'($urandom));
    end
    enable    = 1'b1;
    src_ready = 1'b1;
    idle(20);
    chk("final_drained", 32'(src_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
